// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding
// and the truth-table width helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } scan_state_e;

    function automatic int table_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: loadable down-counter; expire is high once SETTLE cycles have elapsed since load.
// Latency: expire asserts in the SETTLE-th cycle after the loading edge.
// Backpressure: none; load always wins over counting.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expire
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps minterms 0..2**N_IN-1 into a combinational cell, captures and checks s_in.
// Latency: done pulses 2**N_IN*(SETTLE+1)+1 edges after the edge that accepts start.
// Backpressure: start is a level request honoured only in IDLE; ignored while a scan is in flight.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      abcd,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 err_valid,
    output logic [N_IN-1:0]      first_err
);

    localparam int TW = table_width(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

    scan_state_e     state, state_nxt;
    logic [N_IN-1:0] idx, idx_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic [N_IN-1:0] abcd_d;
    logic            busy_d, done_d, pass_d, err_valid_d;
    logic [TW-1:0]   table_d;
    logic [N_IN-1:0] first_err_d;
    logic            timer_load, timer_expire;
    logic            last;

    assign last = (idx == LAST_IDX);

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .expire  (timer_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   if (timer_expire) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last ? FINISH : APPLY;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // abcd is loaded on entry to APPLY so each minterm is held through APPLY and SAMPLE.
    always_comb begin
        abcd_d      = abcd;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        table_d     = table_out;
        err_valid_d = err_valid;
        first_err_d = first_err;
        idx_d       = idx;
        exp_d       = exp_q;
        timer_load  = 1'b0;
        case (state)
            IDLE: begin
                abcd_d = '0;
                if (start) begin
                    exp_d       = expected;
                    idx_d       = '0;
                    table_d     = '0;
                    pass_d      = 1'b0;
                    err_valid_d = 1'b0;
                    first_err_d = '0;
                    busy_d      = 1'b1;
                    timer_load  = 1'b1;
                end
            end
            APPLY: begin
                abcd_d = idx;
            end
            SAMPLE: begin
                table_d[idx] = s_in;
                if ((s_in !== exp_q[idx]) && !err_valid) begin
                    err_valid_d = 1'b1;
                    first_err_d = idx;
                end
                if (last) begin
                    abcd_d = '0;
                end else begin
                    idx_d      = idx + IDX_ONE;
                    abcd_d     = idx + IDX_ONE;
                    timer_load = 1'b1;
                end
            end
            FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                abcd_d = '0;
                pass_d = (table_out == exp_q);
            end
            default: begin
                abcd_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abcd      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            err_valid <= 1'b0;
            first_err <= '0;
            idx       <= '0;
            exp_q     <= '0;
        end else begin
            abcd      <= abcd_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            table_out <= table_d;
            err_valid <= err_valid_d;
            first_err <= first_err_d;
            idx       <= idx_d;
            exp_q     <= exp_d;
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: table-driven scans on a SETTLE=1 instance plus reset,
// held-start and SETTLE=3 sequences; the cell under test is a lookup on fmask.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] expected;
    logic [15:0] fmask;

    logic        start1, s1, busy1, done1, pass1, err1;
    logic [3:0]  abcd1, ferr1;
    logic [15:0] table1;
    logic        start3, s3, busy3, done3, pass3, err3;
    logic [3:0]  abcd3, ferr3;
    logic [15:0] table3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign s1 = fmask[abcd1];
    assign s3 = fmask[abcd3];

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .expected(expected),
        .abcd(abcd1), .s_in(s1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(table1), .err_valid(err1), .first_err(ferr1)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .expected(expected),
        .abcd(abcd3), .s_in(s3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(table3), .err_valid(err3), .first_err(ferr3)
    );

    typedef struct {
        logic [15:0] f;
        logic [15:0] e;
        logic        p;
        logic        ev;
        logic [3:0]  fe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done1 : done3;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy1 : busy3;
    endfunction

    function automatic logic [3:0] get_abcd(input int sel);
        return (sel == 0) ? abcd1 : abcd3;
    endfunction

    // One-cycle start pulse; returns edges-to-done and count of abcd/busy sequence errors.
    task automatic run_scan(input int sel, input logic [15:0] exp_v, output int lat, output int bad);
        int per;
        int exp_a;
        per = (sel == 0) ? 2 : 4;
        lat = -1;
        bad = 0;
        expected = exp_v;
        if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        if (get_abcd(sel) !== 4'h0) bad++;
        if (get_busy(sel) !== 1'b1) bad++;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            exp_a = (n < 16 * per) ? n / per : 0;
            if (get_abcd(sel) !== 4'(exp_a)) bad++;
            if (get_busy(sel) !== (n <= 16 * per)) bad++;
            if (get_done(sel)) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, found, pulses;

        vecs[0] = '{16'h5363, 16'h5363, 1'b1, 1'b0, 4'h0};
        vecs[1] = '{16'h5363, 16'h5362, 1'b0, 1'b1, 4'h0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0};
        vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'h0};
        vecs[4] = '{16'h5363, 16'h4363, 1'b0, 1'b1, 4'hC};
        vecs[5] = '{16'h5363, 16'hD367, 1'b0, 1'b1, 4'h2};
        vecs[6] = '{16'h8000, 16'h0000, 1'b0, 1'b1, 4'hF};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'h0};

        reset_n  = 1'b0;
        start1   = 1'b0;
        start3   = 1'b0;
        expected = 16'h0;
        fmask    = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_abcd", abcd1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_table", table1, 0);
        check("rst_err", err1, 0);
        check("rst_ferr", ferr1, 0);
        check("rst3_all", {abcd3, busy3, done3, pass3, table3, err3, ferr3}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            fmask = vecs[i].f;
            run_scan(0, vecs[i].e, lat, bad);
            check($sformatf("v%0d_latency", i), lat, 33);
            check($sformatf("v%0d_seq_errs", i), bad, 0);
            check($sformatf("v%0d_table", i), table1, vecs[i].f);
            check($sformatf("v%0d_pass", i), pass1, vecs[i].p);
            check($sformatf("v%0d_err_valid", i), err1, vecs[i].ev);
            check($sformatf("v%0d_first_err", i), ferr1, vecs[i].fe);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), done1, 0);
            check($sformatf("v%0d_hold", i), {pass1, err1, ferr1, table1},
                  {vecs[i].p, vecs[i].ev, vecs[i].fe, vecs[i].f});
        end

        // Reset mid-scan while minterm 7 is being driven.
        fmask    = 16'h5363;
        expected = 16'h5362;
        start1   = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        found  = 0;
        for (int n = 0; n < 40; n++) begin
            if (abcd1 == 4'h7) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_reach_7", found, 1);
        check("mid_err_before", err1, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_abcd", abcd1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_table", table1, 0);
        check("mid_rst_err", {err1, ferr1, pass1, done1}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        check("mid_no_done", pulses, 0);
        run_scan(0, 16'h5363, lat, bad);
        check("post_rst_latency", lat, 33);
        check("post_rst_seq_errs", bad, 0);
        check("post_rst_pass", pass1, 1);

        // start held high: back-to-back scans, mid-scan start/expected toggles ignored.
        @(posedge clk); #1;
        fmask    = 16'h5363;
        expected = 16'h5363;
        start1   = 1'b1;
        found    = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                found = 1;
                break;
            end
        end
        check("held_first_done", found, 1);
        for (int k = 0; k < 2; k++) begin
            lat = -1;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk); #1;
                if (n == 5)  expected = 16'h0000;
                if (n == 6)  start1 = 1'b0;
                if (n == 8)  start1 = 1'b1;
                if (n == 30) expected = 16'h5363;
                if (done1) begin
                    lat = n;
                    break;
                end
            end
            check($sformatf("held%0d_period", k), lat, 34);
            check($sformatf("held%0d_pass", k), {pass1, err1, table1}, {1'b1, 1'b0, 16'h5363});
        end
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // SETTLE=3 instance: four cycles per minterm.
        fmask = 16'h5363;
        run_scan(1, 16'h5363, lat, bad);
        check("s3_latency", lat, 65);
        check("s3_seq_errs", bad, 0);
        check("s3_pass", {pass3, err3, table3}, {1'b1, 1'b0, 16'h5363});
        @(posedge clk); #1;
        run_scan(1, 16'h4363, lat, bad);
        check("s3_err_latency", lat, 65);
        check("s3_err_result", {pass3, err3, ferr3}, {1'b0, 1'b1, 4'hC});
        check("s3_idle_other", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
